// File: rtl/mem_addr_sequencer.sv
// rtl/mem_addr_sequencer.sv - LC-3 effective-address and memory-access sequencer
// Drives the address-mux selects and bus/load strobes for memory-class instructions.
module mem_addr_sequencer #(
    parameter int MAX_WAIT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] IR,
    input  logic        mem_ready,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic        GateMARMUX,
    output logic        GateMDR,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EA,
        S_RD1,
        S_IND,
        S_RD2,
        S_WR,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    ir_q, ir_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [3:0]     op;
    logic           wait_expired;
    logic           unused_ir_bits;

    function automatic logic is_legal(input logic [3:0] opc);
        return (opc == OP_LD)  || (opc == OP_ST)  || (opc == OP_LDR) || (opc == OP_STR) ||
               (opc == OP_LDI) || (opc == OP_STI) || (opc == OP_LEA);
    endfunction

    function automatic logic is_indirect(input logic [3:0] opc);
        return (opc == OP_LDI) || (opc == OP_STI);
    endfunction

    function automatic logic is_direct_store(input logic [3:0] opc);
        return (opc == OP_ST) || (opc == OP_STR);
    endfunction

    function automatic logic is_base_rel(input logic [3:0] opc);
        return (opc == OP_LDR) || (opc == OP_STR);
    endfunction

    assign op             = ir_q[15:12];
    assign unused_ir_bits = ^ir_q[11:0];
    assign wait_expired   = (cnt_q == MAX_CNT) && !mem_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // The wait counter defaults to zero, so it is clear on every entry to a memory state.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = '0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ir_d    = IR;
                    err_d   = !is_legal(IR[15:12]);
                    state_d = is_legal(IR[15:12]) ? S_EA : S_DONE;
                end
            end
            S_EA: begin
                if (op == OP_LEA) begin
                    state_d = S_DONE;
                end else if (is_direct_store(op)) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_RD1;
                end
            end
            S_RD1: begin
                if (mem_ready) begin
                    state_d = is_indirect(op) ? S_IND : S_DONE;
                end else if (wait_expired) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IND: begin
                state_d = (op == OP_LDI) ? S_RD2 : S_WR;
            end
            S_RD2, S_WR: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                end else if (wait_expired) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        GateMARMUX = 1'b0;
        GateMDR    = 1'b0;
        LD_MAR     = 1'b0;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = (state_q != S_IDLE);
        case (state_q)
            S_EA: begin
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                if (is_base_rel(op)) begin
                    ADDR1MUX = 1'b1;
                    ADDR2MUX = 2'b01;
                end else begin
                    ADDR1MUX = 1'b0;
                    ADDR2MUX = 2'b10;
                end
            end
            S_RD1, S_RD2: begin
                Mem_OE = 1'b1;
            end
            S_IND: begin
                GateMDR = 1'b1;
                LD_MAR  = 1'b1;
            end
            S_WR: begin
                Mem_WE = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: begin
                busy = (state_q != S_IDLE);
            end
        endcase
        LD_MDR = Mem_OE & mem_ready;
    end

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// tb/tb_mem_addr_sequencer.sv - scoreboard bench for mem_addr_sequencer
// Expected per-cycle output vectors are queued per sequence, then popped and compared each cycle.
module tb_mem_addr_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [15:0] IR;
    logic        mem_ready;
    logic        ADDR1MUX;
    logic [1:0]  ADDR2MUX;
    logic        GateMARMUX, GateMDR, LD_MAR, LD_MDR, Mem_OE, Mem_WE, busy, done, err;

    int total = 0;
    int bad   = 0;

    logic [11:0] exp_q[$];
    bit          rdy_q[$];

    // {ADDR1MUX, ADDR2MUX, GateMARMUX, GateMDR, LD_MAR, LD_MDR, Mem_OE, Mem_WE, busy, done, err}
    localparam logic [11:0] V_IDLE   = 12'b0_00_0_0_0_0_0_0_0_0_0;
    localparam logic [11:0] V_EA_PC  = 12'b0_10_1_0_1_0_0_0_1_0_0;
    localparam logic [11:0] V_EA_BR  = 12'b1_01_1_0_1_0_0_0_1_0_0;
    localparam logic [11:0] V_RD_W   = 12'b0_00_0_0_0_0_1_0_1_0_0;
    localparam logic [11:0] V_RD_R   = 12'b0_00_0_0_0_1_1_0_1_0_0;
    localparam logic [11:0] V_IND    = 12'b0_00_0_1_1_0_0_0_1_0_0;
    localparam logic [11:0] V_WR     = 12'b0_00_0_0_0_0_0_1_1_0_0;
    localparam logic [11:0] V_DN_OK  = 12'b0_00_0_0_0_0_0_0_1_1_0;
    localparam logic [11:0] V_DN_ERR = 12'b0_00_0_0_0_0_0_0_1_1_1;

    mem_addr_sequencer #(.MAX_WAIT(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .IR         (IR),
        .mem_ready  (mem_ready),
        .ADDR1MUX   (ADDR1MUX),
        .ADDR2MUX   (ADDR2MUX),
        .GateMARMUX (GateMARMUX),
        .GateMDR    (GateMDR),
        .LD_MAR     (LD_MAR),
        .LD_MDR     (LD_MDR),
        .Mem_OE     (Mem_OE),
        .Mem_WE     (Mem_WE),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [11:0] outv();
        return {ADDR1MUX, ADDR2MUX, GateMARMUX, GateMDR, LD_MAR, LD_MDR, Mem_OE, Mem_WE, busy, done, err};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic ex(input logic [11:0] v, input bit r);
        exp_q.push_back(v);
        rdy_q.push_back(r);
    endtask

    // Issues start with ir, then drains the queued expectations one cycle at a time.
    task automatic run_seq(input string name, input logic [15:0] ir, input bit poke);
        int cyc;
        logic [11:0] e;
        @(negedge Clk);
        start     = 1'b1;
        IR        = ir;
        mem_ready = 1'b0;
        cyc       = 0;
        while (exp_q.size() > 0) begin
            @(negedge Clk);
            e         = exp_q.pop_front();
            mem_ready = rdy_q.pop_front();
            start     = poke && e[2];
            IR        = 16'($urandom);
            #1 chk($sformatf("%s[%0d]", name, cyc), outv(), e);
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        Reset     = 1'b1;
        start     = 1'b0;
        IR        = 16'h0000;
        mem_ready = 1'b0;
        repeat (2) @(negedge Clk);
        #1 chk("reset_state", outv(), V_IDLE);
        Reset = 1'b0;

        // Reset in the middle of RD1 of an LDI
        @(negedge Clk);
        start = 1'b1;
        IR    = 16'hA000;
        @(negedge Clk);
        start = 1'b0;
        #1 chk("rst_ldi_ea", outv(), V_EA_PC);
        @(negedge Clk);
        #1 chk("rst_ldi_rd1", outv(), V_RD_W);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        #1 chk("rst_ldi_after", outv(), V_IDLE);
        @(negedge Clk);
        #1 chk("rst_ldi_quiet", outv(), V_IDLE);

        ex(V_EA_PC, 1); ex(V_RD_R, 1); ex(V_DN_OK, 1); ex(V_IDLE, 1);
        run_seq("ld_after_rst", 16'h2405, 0);

        ex(V_EA_PC, 1); ex(V_RD_R, 1); ex(V_DN_OK, 1); ex(V_IDLE, 1);
        run_seq("ld", 16'h2405, 0);

        ex(V_EA_BR, 1); ex(V_RD_W, 0); ex(V_RD_W, 0); ex(V_RD_W, 0); ex(V_RD_R, 1);
        ex(V_DN_OK, 1); ex(V_IDLE, 1);
        run_seq("ldr_wait3", 16'h6283, 0);

        ex(V_EA_PC, 1); ex(V_RD_R, 1); ex(V_IND, 1); ex(V_WR, 1); ex(V_DN_OK, 1); ex(V_IDLE, 1);
        run_seq("sti", 16'hB7FF, 0);

        ex(V_EA_PC, 0);
        for (int i = 0; i < 5; i++) ex(V_WR, 0);
        ex(V_DN_ERR, 0); ex(V_IDLE, 0);
        run_seq("st_timeout", 16'h3000, 0);

        ex(V_EA_PC, 1); ex(V_DN_OK, 1); ex(V_IDLE, 1);
        run_seq("lea_after_err", 16'hE00A, 0);

        ex(V_DN_ERR, 1); ex(V_IDLE, 1);
        run_seq("illegal_add", 16'h1021, 0);

        ex(V_DN_ERR, 1); ex(V_IDLE, 1);
        run_seq("illegal_br", 16'h0E05, 0);

        ex(V_EA_PC, 1); ex(V_RD_R, 1); ex(V_IND, 1); ex(V_RD_R, 1); ex(V_DN_OK, 1);
        ex(V_IDLE, 1); ex(V_IDLE, 1);
        run_seq("ldi_start_busy", 16'hA123, 1);

        ex(V_EA_BR, 1); ex(V_WR, 0); ex(V_WR, 1); ex(V_DN_OK, 1); ex(V_IDLE, 1);
        run_seq("str_wait1", 16'h7040, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
